prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 256, is the largest accepted i_word_count value; range 1..65535.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_start  input  1  one-cycle request to begin a load session.
REQ-006 i_word_count  input  16  number of 32-bit instruction words in the session; sampled with i_start.
REQ-007 i_byte_valid  input  1  serial source presents a byte.
REQ-008 i_byte  input  8  serial data byte.
REQ-009 o_byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 o_imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 o_imem_addr  output  32  byte address of the word being written.
REQ-012 o_imem_wdata  output  32  assembled instruction word.
REQ-013 o_cpu_rst  output  1  holds the single-cycle core in reset while high.
REQ-014 o_busy  output  1  session in progress (RECV, WRITE or CHECK).
REQ-015 o_done  output  1  last session completed with a good checksum.
REQ-016 o_err  output  1  last session failed (checksum mismatch or count out of range).

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE, CHECK, DONE and ERR.
REQ-018 A byte SHALL transfer only on a cycle with i_byte_valid && o_byte_ready.
REQ-019 o_byte_ready SHALL be high only in RECV and CHECK.
REQ-020 i_start SHALL be accepted in IDLE, DONE or ERR, and ignored in RECV, WRITE and CHECK.
REQ-021 On accepted i_start: latch count; clear byte index, word index and checksum; set o_cpu_rst=1; clear o_done/o_err.
REQ-022 Accepted i_start with count in 1..MAX_WORDS SHALL go to RECV next cycle.
REQ-023 Accepted i_start with count 0 or count > MAX_WORDS SHALL go to ERR next cycle.
REQ-024 Bytes are little-endian: the first byte of each word SHALL land in wdata[7:0] and the fourth in wdata[31:24].
REQ-025 After the fourth byte of a word the FSM SHALL enter WRITE for exactly one cycle with o_imem_we=1.
REQ-026 During WRITE, o_imem_addr SHALL equal BASE_ADDR + 4*word_index (32-bit wrap) and o_imem_wdata SHALL hold the assembled word.
REQ-027 o_imem_we SHALL be 0 in every state other than WRITE.
REQ-028 After WRITE: if word_index+1 < count, increment word_index and return to RECV; otherwise go to CHECK.
REQ-029 Running checksum SHALL be the XOR of every data byte accepted in the session.
REQ-030 In CHECK, the next accepted byte is the checksum byte: equal to the running XOR -> DONE, else ERR.
REQ-031 In DONE: o_cpu_rst=0 and o_done=1. In ERR: o_cpu_rst=1 and o_err=1. Both states hold until the next accepted i_start or reset.
REQ-032 o_busy SHALL equal (state is RECV, WRITE or CHECK).
REQ-033 Minimum word latency is 5 cycles (4 byte beats plus 1 WRITE); source stalls (valid low) add cycles without losing state.

Reset
REQ-034 i_rst high on an edge SHALL force IDLE from any state, including mid-word and mid-WRITE; a partial word SHALL never be written.
REQ-035 Reset values SHALL be: o_cpu_rst=1; o_imem_we=0; o_byte_ready=0; o_busy=0; o_done=0; o_err=0; o_imem_addr=BASE_ADDR; o_imem_wdata=0; all indices and the checksum 0.

Structure
REQ-036 Package loader_pkg SHALL hold the state enum loader_state_t and the constant BYTES_PER_WORD=4.
REQ-037 Byte assembly (shift register plus 2-bit byte index) SHALL be sub-module word_assembler; the FSM, counters and checksum stay in prog_loader.

Verification
REQ-038 Count=1; bytes 13,00,50,00; then checksum 43 -> one WRITE with addr 0x0 and wdata 0x00500013; o_done=1 and o_cpu_rst=0.
REQ-039 Count=3 with i_byte_valid toggling every other cycle -> WRITE at addr 0x0, 0x4, 0x8; data intact; no extra o_imem_we pulses.
REQ-040 Count=2 with a bad checksum byte -> both words written, then o_err=1 and o_cpu_rst stays 1; a following good session -> o_done=1.
REQ-041 Count=0, and separately count=MAX_WORDS+1 -> ERR on the next cycle, no writes, o_byte_ready never asserts.
REQ-042 i_rst asserted after the second byte of word 1 -> IDLE next cycle, reset values on all outputs, no write of the partial word.
REQ-043 i_start pulsed during RECV -> ignored: count, address and checksum unchanged, and the session completes normally.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// Collects four serial bytes into a little-endian 32-bit word.
module word_assembler
    import loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [7:0] r_lane [BYTES_PER_WORD];
    logic [1:0] r_byte_idx;

    // Bytes enter at the top lane and shift down, so the first byte ends in lane 0.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            always_ff @(posedge i_clk) begin
                if (i_rst || i_clear) begin
                    r_lane[gi] <= 8'd0;
                end else if (i_accept) begin
                    if (gi == BYTES_PER_WORD - 1) begin
                        r_lane[gi] <= i_byte;
                    end else begin
                        r_lane[gi] <= r_lane[gi + 1];
                    end
                end
            end
            assign o_word[gi*8 +: 8] = r_lane[gi];
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_byte_idx <= 2'd0;
        end else if (i_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
        end
    end

    assign o_word_done = i_accept && (r_byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/prog_loader.sv
// Serial-byte program loader: fills instruction memory, verifies an XOR checksum,
// and holds the core in reset until a session completes cleanly.
module prog_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_word_count,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_cpu_rst,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    loader_state_t r_state;
    loader_state_t w_state_next;
    logic [15:0]   r_count;
    logic [15:0]   r_word_idx;
    logic [7:0]    r_csum;

    logic w_start_ok;
    logic w_count_ok;
    logic w_byte_xfer;
    logic w_word_done;
    logic w_last_word;
    logic w_asm_accept;

    assign w_start_ok   = i_start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_count_ok   = (i_word_count != 16'd0) && (int'(i_word_count) <= MAX_WORDS);
    assign w_byte_xfer  = i_byte_valid && o_byte_ready;
    assign w_asm_accept = w_byte_xfer && (r_state == S_RECV);
    assign w_last_word  = ({1'b0, r_word_idx} + 17'd1) >= {1'b0, r_count};

    word_assembler u_asm (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_start_ok),
        .i_accept    (w_asm_accept),
        .i_byte      (i_byte),
        .o_word      (o_imem_wdata),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_byte_ready = 1'b0;
        o_imem_we    = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_cpu_rst    = 1'b1;

        case (r_state)
            S_RECV: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (w_word_done) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_imem_we    = 1'b1;
                o_busy       = 1'b1;
                w_state_next = w_last_word ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (w_byte_xfer) begin
                    w_state_next = (i_byte == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                o_done    = 1'b1;
                o_cpu_rst = 1'b0;
            end
            S_ERR: begin
                o_err = 1'b1;
            end
            default: ;
        endcase

        // A start request only reaches here from IDLE, DONE or ERR.
        if (w_start_ok) begin
            w_state_next = w_count_ok ? S_RECV : S_ERR;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_csum     <= 8'd0;
        end else if (w_start_ok) begin
            r_count    <= i_word_count;
            r_word_idx <= 16'd0;
            r_csum     <= 8'd0;
        end else begin
            if (w_asm_accept) begin
                r_csum <= r_csum ^ i_byte;
            end
            if (r_state == S_WRITE && !w_last_word) begin
                r_word_idx <= r_word_idx + 16'd1;
            end
        end
    end

    assign o_imem_addr = BASE_ADDR + {14'd0, r_word_idx, 2'b00};

endmodule
